// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the byte-enable width.
package lsu_pkg;

   localparam int LSU_BE_W = 4;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment check, byte enables,
// store-data replication and load-data extract/extend.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                we_i,
   input  logic [2:0]          funct3_i,
   input  logic [1:0]          offset_i,
   input  logic [WIDTH-1:0]    wdata_i,
   input  logic [WIDTH-1:0]    rdata_i,
   output logic                err_o,
   output logic [LSU_BE_W-1:0] be_o,
   output logic [WIDTH-1:0]    wdata_o,
   output logic [WIDTH-1:0]    rdata_o
);

   logic             illegal;
   logic             misaligned;
   logic [WIDTH-1:0] shifted;

   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      case (funct3_i)
         LSU_B:  misaligned = 1'b0;
         LSU_H:  misaligned = offset_i[0];
         LSU_W:  misaligned = |offset_i;
         LSU_BU: illegal    = we_i;
         LSU_HU: begin
            illegal    = we_i;
            misaligned = offset_i[0];
         end
         default: illegal = 1'b1;
      endcase
   end

   assign err_o = illegal | misaligned;

   // funct3[1:0] encodes the access size for every legal op
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << offset_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_o    = 4'b0011 << offset_i;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: begin
            be_o    = 4'b1111;
            wdata_o = wdata_i;
         end
      endcase
   end

   assign shifted = rdata_i >> {offset_i, 3'b000};

   always_comb begin
      rdata_o = '0;
      case (funct3_i)
         LSU_B:   rdata_o = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
         LSU_H:   rdata_o = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
         LSU_W:   rdata_o = rdata_i;
         LSU_BU:  rdata_o = {{(WIDTH-8){1'b0}}, shifted[7:0]};
         LSU_HU:  rdata_o = {{(WIDTH-16){1'b0}}, shifted[15:0]};
         default: rdata_o = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit on a req/gnt/rvalid bus.
// Define LSU_BUS_TIMEOUT_EN to abort bus waits after TIMEOUT_CYCLES cycles.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          req_funct3,
   input  logic [WIDTH-1:0]    req_addr,
   input  logic [WIDTH-1:0]    req_wdata,
   input  logic [4:0]          req_rd,
   output logic                mem_req,
   output logic                mem_we,
   output logic [WIDTH-1:0]    mem_addr,
   output logic [LSU_BE_W-1:0] mem_be,
   output logic [WIDTH-1:0]    mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [WIDTH-1:0]    mem_rdata,
   output logic                rsp_valid,
   output logic [WIDTH-1:0]    rsp_rdata,
   output logic [4:0]          rsp_rd,
   output logic                rsp_err,
   output logic                busy
);

   if (WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("load_store_unit: WIDTH must be 32 and TIMEOUT_CYCLES >= 1");
   end

   lsu_state_t       state_q, state_d;
   logic [WIDTH-1:0] addr_q, wdata_q, rdata_q, rdata_d;
   logic [2:0]       funct3_q;
   logic [4:0]       rd_q;
   logic             we_q, err_q, err_d;
   logic             idle, accept, timeout;

   logic                al_we;
   logic [2:0]          al_funct3;
   logic [1:0]          al_offset;
   logic [WIDTH-1:0]    al_wdata, al_wdata_rep, al_rdata;
   logic [LSU_BE_W-1:0] al_be;
   logic                al_err;

   assign idle   = (state_q == S_IDLE);
   assign accept = req_valid && idle;

   // In IDLE the lane logic checks the incoming request; afterwards it
   // works from the captured copy so bus fields stay stable.
   assign al_we     = idle ? req_we            : we_q;
   assign al_funct3 = idle ? req_funct3        : funct3_q;
   assign al_offset = idle ? req_addr[1:0]     : addr_q[1:0];
   assign al_wdata  = idle ? req_wdata         : wdata_q;

   lsu_align #(.WIDTH(WIDTH)) u_align (
      .we_i     (al_we),
      .funct3_i (al_funct3),
      .offset_i (al_offset),
      .wdata_i  (al_wdata),
      .rdata_i  (mem_rdata),
      .err_o    (al_err),
      .be_o     (al_be),
      .wdata_o  (al_wdata_rep),
      .rdata_o  (al_rdata)
   );

`ifdef LSU_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout = ((state_q == S_REQ && !mem_gnt) || (state_q == S_WAIT && !mem_rvalid))
                    && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counter restarts whenever the state changes
   always_comb begin
      cnt_d = '0;
      if ((state_q == S_REQ || state_q == S_WAIT) && state_d == state_q)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req_valid) state_d = al_err ? S_RESP : S_REQ;
         S_REQ: begin
            if (mem_gnt)      state_d = we_q ? S_RESP : S_WAIT;
            else if (timeout) state_d = S_RESP;
         end
         S_WAIT: if (mem_rvalid || timeout) state_d = S_RESP;
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      err_d   = err_q;
      rdata_d = rdata_q;
      if (accept) begin
         err_d   = al_err;
         rdata_d = '0;
      end else if (state_q == S_WAIT && mem_rvalid) begin
         rdata_d = al_rdata;
      end else if (timeout) begin
         err_d   = 1'b1;
         rdata_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         we_q     <= 1'b0;
         funct3_q <= '0;
         wdata_q  <= '0;
         rd_q     <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (accept) begin
            addr_q   <= req_addr;
            we_q     <= req_we;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            rd_q     <= req_rd;
         end
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      req_ready = 1'b0;
      busy      = 1'b1;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_rd    = '0;
      rsp_err   = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         S_REQ: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
            mem_be    = al_be;
            mem_wdata = al_wdata_rep;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            rsp_rdata = rdata_q;
            rsp_rd    = rd_q;
            rsp_err   = err_q;
         end
         default: ;
      endcase
   end

endmodule
